// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the audio recorder and playback engines.
//   SDRAM_AW     SDRAM word-address width
//   SAMPLE_W     audio sample width
//   WORD_W       SDRAM data word width (two samples per word)
//   sample_t     one audio sample
//   play_state_e playback engine FSM states
package audio_pkg;

    localparam int SDRAM_AW = 23;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        PLAY_IDLE,
        PLAY_FETCH,
        PLAY_PAUSE,
        PLAY_DRAIN,
        PLAY_ABORT,
        PLAY_DONE
    } play_state_e;

    // States in which the sample buffer feeds the DAC and stop is honoured.
    function automatic logic play_active(input play_state_e s);
        return (s == PLAY_FETCH) || (s == PLAY_PAUSE) || (s == PLAY_DRAIN);
    endfunction

endpackage

// File: rtl/play_fifo.sv
// play_fifo: sample buffer between the SDRAM fetch side and the DAC side.
// Accepts one 32-bit SDRAM word per push (low half stored first, then high
// half) and hands out one 16-bit sample per pop.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       empties the buffer; wins over a simultaneous push/pop
//   push        write both halves of push_word (dropped if < 2 slots free)
//   push_word   SDRAM word to unpack
//   pop         remove the head sample (ignored when empty)
//   head        current head sample, 0 when empty
//   empty       no samples buffered
//   free        number of unused sample slots
module play_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_word,
    input  logic                     pop,
    output sample_t                  head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int PW = $clog2(DEPTH);

    sample_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   wr_ptr_p1;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty     = (count == '0);
    assign free      = (PW+1)'(DEPTH) - count;
    assign wr_ptr_p1 = wr_ptr + PW'(1);
    assign do_push   = push && (free >= (PW+1)'(2));
    assign do_pop    = pop && !empty;
    assign head      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(2);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (do_push ? (PW+1)'(2) : '0) - (do_pop ? (PW+1)'(1) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr]    <= push_word[SAMPLE_W-1:0];
            mem[wr_ptr_p1] <= push_word[WORD_W-1:SAMPLE_W];
        end
    end

endmodule

// File: rtl/play_core.sv
// play_core: playback engine. Fetches 32-bit words from SDRAM over an
// inclusive address range and streams them as 16-bit samples (low half
// first) to the DAC path over valid/ready. Supports pause and stop.
// Build option: define PLAY_LOOP_EN to restart at the start address after
// the last word and keep playing until stopped.
//   i_clk, i_rst          clock, asynchronous active-low reset
//   play_start            pulse: begin playback (IDLE only)
//   play_start_addr/_end  inclusive word range, sampled on play_start
//   play_pause            level: hold playback
//   play_stop             abort playback
//   play_done             1-cycle completion/abort pulse
//   play_read/play_addr   SDRAM read request and word address
//   play_readdata         SDRAM data, valid with play_sdram_finished
//   play_sdram_finished   SDRAM completion strobe
//   play_audio_*          sample stream to the DAC (valid/ready)
module play_core
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = SDRAM_AW
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                play_start,
    input  logic [AW-1:0]       play_start_addr,
    input  logic [AW-1:0]       play_end_addr,
    input  logic                play_pause,
    input  logic                play_stop,
    output logic                play_done,
    output logic                play_read,
    output logic [AW-1:0]       play_addr,
    input  logic [WORD_W-1:0]   play_readdata,
    input  logic                play_sdram_finished,
    output logic [SAMPLE_W-1:0] play_audio_data,
    output logic                play_audio_valid,
    input  logic                play_audio_ready
);

`ifdef PLAY_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    play_state_e    state;
    play_state_e    next_state;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  start_q;
    logic [AW-1:0]  end_q;
    logic           range_bad;
    logic           read_q;
    logic           lock_q;

    logic           active;
    logic           paused;
    logic           at_end;
    logic           issue;
    logic           push;
    logic           pop;
    logic           flush;
    logic           valid;
    logic           fifo_empty;
    logic [FW-1:0]  fifo_free;
    sample_t        fifo_head;

    assign active = play_active(state);
    assign paused = play_pause || (state == PLAY_PAUSE);
    assign at_end = (addr_q == end_q);

    // Only one read in flight, and only when both halves of the word fit.
    assign issue  = (state == PLAY_FETCH) && !read_q && !range_bad &&
                    !play_pause && !play_stop && (fifo_free >= FW'(2));

    // lock_q keeps a presented sample valid across a pause until it is taken.
    assign valid  = active && !fifo_empty && (!paused || lock_q);
    assign pop    = valid && play_audio_ready;
    assign push   = read_q && play_sdram_finished && active && !play_stop;
    assign flush  = (active && play_stop) || (state == PLAY_ABORT);

    play_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .flush     (flush),
        .push      (push),
        .push_word (play_readdata),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    always_comb begin
        next_state = state;
        case (state)
            PLAY_IDLE: begin
                if (play_start) next_state = PLAY_FETCH;
            end
            PLAY_FETCH: begin
                if (play_stop)                        next_state = PLAY_ABORT;
                else if (range_bad)                   next_state = PLAY_DONE;
                else if (issue && at_end && !LOOP_EN) next_state = PLAY_DRAIN;
                else if (play_pause)                  next_state = PLAY_PAUSE;
            end
            PLAY_PAUSE: begin
                if (play_stop)        next_state = PLAY_ABORT;
                else if (!play_pause) next_state = PLAY_FETCH;
            end
            PLAY_DRAIN: begin
                // Stop wins over a drain that would complete this cycle.
                if (play_stop)                    next_state = PLAY_ABORT;
                else if (!read_q && fifo_empty)   next_state = PLAY_DONE;
            end
            PLAY_ABORT: begin
                if (!read_q || play_sdram_finished) next_state = PLAY_DONE;
            end
            PLAY_DONE: begin
                next_state = PLAY_IDLE;
            end
            default: begin
                next_state = PLAY_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= PLAY_IDLE;
            addr_q    <= '0;
            start_q   <= '0;
            end_q     <= '0;
            range_bad <= 1'b0;
            read_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state  <= next_state;
            lock_q <= valid && !play_audio_ready;

            if (state == PLAY_IDLE && play_start) begin
                addr_q    <= play_start_addr;
                start_q   <= play_start_addr;
                end_q     <= play_end_addr;
                range_bad <= (play_end_addr < play_start_addr);
            end

            if (issue) begin
                read_q <= 1'b1;
            end else if (play_sdram_finished) begin
                read_q <= 1'b0;
            end

            if (read_q && play_sdram_finished) begin
                if (!at_end)      addr_q <= addr_q + AW'(1);
                else if (LOOP_EN) addr_q <= start_q;
            end
        end
    end

    assign play_done        = (state == PLAY_DONE);
    assign play_read        = read_q;
    assign play_addr        = addr_q;
    assign play_audio_valid = valid;
    assign play_audio_data  = fifo_head;

endmodule

// File: tb/tb_play_core.sv
module tb_play_core;
    import audio_pkg::*;

    localparam int AW = 23;

    logic            i_clk;
    logic            i_rst;
    logic            play_start;
    logic [AW-1:0]   play_start_addr;
    logic [AW-1:0]   play_end_addr;
    logic            play_pause;
    logic            play_stop;
    logic            play_done;
    logic            play_read;
    logic [AW-1:0]   play_addr;
    logic [31:0]     play_readdata;
    logic            play_sdram_finished;
    logic [15:0]     play_audio_data;
    logic            play_audio_valid;
    logic            play_audio_ready;

    play_core #(
        .FIFO_DEPTH (8),
        .AW         (AW)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .play_start          (play_start),
        .play_start_addr     (play_start_addr),
        .play_end_addr       (play_end_addr),
        .play_pause          (play_pause),
        .play_stop           (play_stop),
        .play_done           (play_done),
        .play_read           (play_read),
        .play_addr           (play_addr),
        .play_readdata       (play_readdata),
        .play_sdram_finished (play_sdram_finished),
        .play_audio_data     (play_audio_data),
        .play_audio_valid    (play_audio_valid),
        .play_audio_ready    (play_audio_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SDRAM responder (drives at negedge + 2) ----------------
    int             lat = 2;
    logic           busy = 1'b0;
    int             cnt = 0;
    logic [AW-1:0]  req_addr = '0;
    logic [AW-1:0]  rd_log [$];
    int             fin_cnt = 0;
    int             fin_cyc = -1;
    int             first_fin_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        case (a)
            23'h10:  return 32'hBBBBAAAA;
            23'h11:  return 32'hDDDDCCCC;
            default: return {a[7:0], 8'h5A, a[7:0], 8'hA5};
        endcase
    endfunction

    initial begin
        play_sdram_finished = 1'b0;
        play_readdata       = '0;
        forever begin
            @(negedge i_clk); #2;
            play_sdram_finished = 1'b0;
            if (!i_rst) begin
                busy = 1'b0;
            end else if (busy) begin
                if (cnt <= 1) begin
                    play_sdram_finished = 1'b1;
                    play_readdata = mem_word(req_addr);
                    busy = 1'b0;
                    fin_cnt++;
                    fin_cyc = cyc;
                    if (first_fin_cyc < 0) first_fin_cyc = cyc;
                end else begin
                    cnt--;
                end
            end else if (play_read) begin
                busy = 1'b1;
                cnt = lat;
                req_addr = play_addr;
                rd_log.push_back(play_addr);
            end
        end
    end

    // ---------------- DAC sink and monitors (sample at negedge + 3) ----------
    logic           ready_req = 1'b0;
    logic [15:0]    got_q [$];
    int             first_valid_cyc = -1;
    logic           hold_pending = 1'b0;
    logic [15:0]    hold_data = '0;
    logic           stall_bad = 1'b0;
    logic           addr_bad = 1'b0;
    logic           read_drop = 1'b0;
    int             done_cnt = 0;
    int             done_cyc = -1;

    initial begin
        play_audio_ready = 1'b0;
        forever begin
            @(negedge i_clk); #2;
            play_audio_ready = ready_req;
            #1;
            if (play_audio_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_pending && i_rst &&
                (!play_audio_valid || play_audio_data !== hold_data)) stall_bad = 1'b1;
            hold_pending = play_audio_valid && !play_audio_ready && !play_stop && i_rst;
            hold_data    = play_audio_data;
            if (play_audio_valid && play_audio_ready) got_q.push_back(play_audio_data);
            if (busy && i_rst) begin
                if (!play_read) read_drop = 1'b1;
                if (play_addr !== req_addr) addr_bad = 1'b1;
            end
            if (play_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge i_clk); #1;
    endtask

    function automatic logic [15:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    function automatic logic [AW-1:0] rd_at(input int i);
        if (i < rd_log.size()) return rd_log[i];
        return 'x;
    endfunction

    task automatic clear_logs();
        rd_log.delete();
        got_q.delete();
        done_cnt = 0;
        first_fin_cyc = -1;
        first_valid_cyc = -1;
        stall_bad = 1'b0;
        addr_bad = 1'b0;
        read_drop = 1'b0;
    endtask

    int s_cyc = 0;

    task automatic start_play(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        play_start_addr = sa;
        play_end_addr   = ea;
        play_start      = 1'b1;
        s_cyc           = cyc;
        tick();
        play_start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_reads(input int n, input int budget, input string tag);
        int i = 0;
        while (!(rd_log.size() >= n && play_read) && i < budget) begin
            tick();
            i++;
        end
        check({tag, "_read_seen"}, 32'(rd_log.size() >= n && play_read), 32'd1);
    endtask

    // Checks n words starting at base were read in order and streamed out.
    task automatic check_run(input string tag, input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        check({tag, "_nsamp"}, 32'(got_q.size()), 32'(2 * n));
        check({tag, "_nread"}, 32'(rd_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            check($sformatf("%s_addr%0d", tag, i), 32'(rd_at(i)), 32'(a));
            check($sformatf("%s_lo%0d", tag, i), 32'(got_at(2 * i)),     32'({a[7:0], 8'hA5}));
            check($sformatf("%s_hi%0d", tag, i), 32'(got_at(2 * i + 1)), 32'({a[7:0], 8'h5A}));
        end
    endtask

    // ---------------- directed sequence ----------------
    logic pv_bad;
    logic pr_bad;
    int   f0;
    int   k;

    initial begin
        i_rst           = 1'b0;
        play_start      = 1'b0;
        play_start_addr = '0;
        play_end_addr   = '0;
        play_pause      = 1'b0;
        play_stop       = 1'b0;
        repeat (3) tick();

        check("rst_read",  32'(play_read),        32'd0);
        check("rst_addr",  32'(play_addr),        32'd0);
        check("rst_valid", 32'(play_audio_valid), 32'd0);
        check("rst_data",  32'(play_audio_data),  32'd0);
        check("rst_done",  32'(play_done),        32'd0);
        i_rst = 1'b1;
        repeat (2) tick();

        // T1: two words, DAC always ready
        lat = 3; ready_req = 1'b1; clear_logs();
        start_play(23'h10, 23'h11);
        wait_done(200, "t1");
        repeat (3) tick();
        check("t1_nsamp", 32'(got_q.size()), 32'd4);
        check("t1_s0", 32'(got_at(0)), 32'hAAAA);
        check("t1_s1", 32'(got_at(1)), 32'hBBBB);
        check("t1_s2", 32'(got_at(2)), 32'hCCCC);
        check("t1_s3", 32'(got_at(3)), 32'hDDDD);
        check("t1_rd0", 32'(rd_at(0)), 32'h10);
        check("t1_rd1", 32'(rd_at(1)), 32'h11);
        check("t1_nread", 32'(rd_log.size()), 32'd2);
        check("t1_done_pulses", 32'(done_cnt), 32'd1);
        check("t1_first_lat", 32'(first_valid_cyc - first_fin_cyc), 32'd1);
        check("t1_idle_read", 32'(play_read), 32'd0);
        check("t1_idle_valid", 32'(play_audio_valid), 32'd0);

        // T2: DAC stalled, buffer fills, then drains without loss
        lat = 2; ready_req = 1'b0; clear_logs();
        start_play(23'h30, 23'h37);
        repeat (30) tick();
        check("t2_fill_reads", 32'(rd_log.size()), 32'd4);
        check("t2_fill_read", 32'(play_read), 32'd0);
        check("t2_fill_valid", 32'(play_audio_valid), 32'd1);
        check("t2_fill_head", 32'(play_audio_data), 32'h30A5);
        check("t2_fill_nsamp", 32'(got_q.size()), 32'd0);
        ready_req = 1'b1;
        wait_done(400, "t2");
        repeat (3) tick();
        check_run("t2", 23'h30, 8);
        check("t2_stable", 32'(stall_bad), 32'd0);
        check("t2_addr_stable", 32'(addr_bad), 32'd0);

        // T3: pause while the first read is outstanding
        lat = 6; ready_req = 1'b1; clear_logs();
        start_play(23'h12, 23'h14);
        wait_reads(1, 50, "t3");
        play_pause = 1'b1;
        f0 = fin_cnt;
        k = 0;
        while (fin_cnt == f0 && k < 50) begin
            tick();
            k++;
        end
        check("t3_read_completes", 32'(fin_cnt != f0), 32'd1);
        pv_bad = 1'b0; pr_bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (play_audio_valid) pv_bad = 1'b1;
            if (play_read)        pr_bad = 1'b1;
        end
        check("t3_valid_paused", 32'(pv_bad), 32'd0);
        check("t3_no_read_paused", 32'(pr_bad), 32'd0);
        check("t3_nread_paused", 32'(rd_log.size()), 32'd1);
        play_pause = 1'b0;
        wait_done(200, "t3");
        repeat (3) tick();
        check_run("t3", 23'h12, 3);

        // T4: stop during the second read with samples buffered
        lat = 4; ready_req = 1'b0; clear_logs();
        start_play(23'h40, 23'h47);
        wait_reads(2, 60, "t4");
        check("t4_valid_before", 32'(play_audio_valid), 32'd1);
        play_stop = 1'b1;
        f0 = fin_cnt;
        tick();
        play_stop = 1'b0;
        check("t4_valid_after_stop", 32'(play_audio_valid), 32'd0);
        check("t4_read_held", 32'(play_read), 32'd1);
        k = 0;
        while (fin_cnt == f0 && k < 50) begin
            tick();
            k++;
        end
        check("t4_finished", 32'(fin_cnt != f0), 32'd1);
        wait_done(20, "t4");
        check("t4_done_lat", 32'(done_cyc - fin_cyc), 32'd1);
        ready_req = 1'b1;
        repeat (5) tick();
        check("t4_flushed", 32'(got_q.size()), 32'd0);
        check("t4_valid_end", 32'(play_audio_valid), 32'd0);
        check("t4_nread", 32'(rd_log.size()), 32'd2);
        check("t4_read_drop", 32'(read_drop), 32'd0);
        check("t4_done_pulses", 32'(done_cnt), 32'd1);

        // T5: end below start
        clear_logs();
        start_play(23'h08, 23'h05);
        wait_done(20, "t5");
        check("t5_done_lat", 32'(done_cyc - s_cyc), 32'd2);
        repeat (3) tick();
        check("t5_nread", 32'(rd_log.size()), 32'd0);
        check("t5_done_pulses", 32'(done_cnt), 32'd1);

`ifdef PLAY_LOOP_EN
        // T6: looping playback until stopped
        lat = 2; ready_req = 1'b1; clear_logs();
        start_play(23'h20, 23'h21);
        wait_reads(6, 200, "t6");
        for (int i = 0; i < 6; i++)
            check($sformatf("t6_addr%0d", i), 32'(rd_at(i)), (i % 2 == 1) ? 32'h21 : 32'h20);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_s0", 32'(got_at(0)), 32'h20A5);
        check("t6_s1", 32'(got_at(1)), 32'h205A);
        check("t6_s2", 32'(got_at(2)), 32'h21A5);
        check("t6_s3", 32'(got_at(3)), 32'h215A);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        wait_done(50, "t6");
`endif

        // T7: reset in the middle of a read
        lat = 5; ready_req = 1'b0; clear_logs();
        start_play(23'h50, 23'h57);
        wait_reads(2, 60, "t7");
        i_rst = 1'b0;
        #1;
        check("t7_read",  32'(play_read),        32'd0);
        check("t7_addr",  32'(play_addr),        32'd0);
        check("t7_valid", 32'(play_audio_valid), 32'd0);
        check("t7_data",  32'(play_audio_data),  32'd0);
        check("t7_done",  32'(play_done),        32'd0);
        repeat (2) tick();
        i_rst = 1'b1;
        tick();
        clear_logs();
        ready_req = 1'b1;
        start_play(23'h60, 23'h60);
        wait_done(100, "t7");
        repeat (3) tick();
        check_run("t7", 23'h60, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_bad);
        $fatal(1);
    end

endmodule
